regfile_write_scheduler: RTL and testbench
==========================================

// Module: regfile_write_scheduler
// PURPOSE
//  Arbitrates NUM_REQ write-back sources (ALU, MUL, LOAD, ...) onto the two write ports of the
//  32x32 register file, which has a single shared write enable. Grants up to 2 writes/cycle,
//  never two different values to one register in a cycle, never writes $zero.
//  Sits between the execute/memory stages and the register file write side.
// PARAMETERS
//  NUM_REQ  3   number of write-back requesters (2..8)
//  DATA_W   32  register data width
//  ADDR_W   5   register index width
// PORTS
//  clock            in   1               rising-edge clock
//  reset_n          in   1               asynchronous, active-low reset
//  hold             in   1               1 = freeze: no grants this cycle
//  req_valid        in   NUM_REQ         requester i has a write pending
//  req_addr         in   NUM_REQ*ADDR_W  destination index, requester i at [i*ADDR_W +: ADDR_W]
//  req_data         in   NUM_REQ*DATA_W  write value, requester i at [i*DATA_W +: DATA_W]
//  req_ready        out  NUM_REQ         combinational: request i accepted this cycle
//  signal_reg_write out  1               shared write enable to register file
//  write_register1  out  ADDR_W          port-1 index
//  write_register2  out  ADDR_W          port-2 index
//  write_data1      out  DATA_W          port-1 data
//  write_data2      out  DATA_W          port-2 data
//  drop_count       out  8               saturating count of $zero-targeted writes discarded
// BEHAVIOUR
//  - Handshake: transfer on req_valid[i] & req_ready[i]. Requester holds addr/data stable
//    while valid & !ready. req_ready depends on req_valid/req_addr/hold/rr_ptr only.
//  - Arbitration (rr_ptr in 0..NUM_REQ-1): scan i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    First valid with addr!=0 -> slot1. Next valid with addr!=0 and addr!=slot1 addr -> slot2.
//    Valid requests with addr==0: ready=1, consume no slot, drop_count+1 (sat at 255).
//    Same-addr loser and all others beyond 2 slots: ready=0, retry next cycle.
//  - rr_ptr <= (index of last granted slot)+1 mod NUM_REQ; unchanged if no slot granted.
//  - Latency 1: outputs registered. Cycle after >=1 grant: signal_reg_write=1.
//    Two grants: port1=slot1, port2=slot2. One grant: port2 duplicates port1 (addr and data)
//    so the shared enable is harmless. No grant: signal_reg_write=0, addr/data hold.
//  - hold=1: all req_ready=0 (including addr==0), no drop count, next-cycle enable=0.
//  - Reset (async, any time): signal_reg_write=0, write_register1/2=0, write_data1/2=0,
//    drop_count=0, rr_ptr=0. Grants in the cycle reset asserts are lost (not written).
//    Outputs stay reset until first rising edge with reset_n=1.
//  - Invariant: signal_reg_write=1 implies write_register1!=0, write_register2!=0, and
//    (write_register1==write_register2) implies write_data1==write_data2.
// STRUCTURE
//  - Package regfile_sched_pkg: ADDR_W/DATA_W defaults, REG_ZERO=5'd0, DROP_W=8,
//    typedef wb_slot_t {valid, addr, data}.
//  - Sub-module rr_pick: masked round-robin find-first (inputs: candidate mask, start ptr;
//    outputs: found, index). Instantiated twice: slot1 on eligible mask, slot2 on eligible
//    mask minus slot1 index and minus entries matching slot1 addr.
//  - Top: eligibility masks, rr_ptr register, output register stage, drop counter.
// TESTING
//  1. req0 r3=0xAAAA, req1 r7=0xBBBB, same cycle, rr_ptr=0 -> both ready; next cycle
//     enable=1, wr1=3/0xAAAA, wr2=7/0xBBBB; rr_ptr=2.
//  2. Only req2 r9=0x1234 -> next cycle enable=1, wr1=wr2=9, data1=data2=0x1234.
//  3. req0 and req1 both r5 (0x11, 0x22), ptr=0 -> cycle A writes r5=0x11 only (port2
//     duplicate), req1 ready=0; cycle B writes r5=0x22.
//  4. req0 r0, req1 r4, req2 r6 -> all ready; writes r4,r6; drop_count=1; r0 never on ports.
//  5. All 3 valid continuously, distinct addrs, 6 cycles -> each requester granted 4 times
//     (fairness); hold=1 for 2 cycles mid-stream -> no ready, enable=0 following cycles.
//  6. reset_n low mid-stream (between edges) -> outputs 0 immediately; after release
//     first grant starts from requester 0; drop_count=0.

Source files
------------

// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
package regfile_sched_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DROP_W     = 8;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_slot_t;

endpackage

// File: rtl/regfile_write_scheduler_rr_pick.sv
// Round-robin find-first: returns the first set bit of i_mask scanning upward
// from i_start and wrapping modulo N.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_mask,
  input  logic [PTR_W-1:0] i_start,
  output logic             o_found,
  output logic [PTR_W-1:0] o_idx
);

  int w_pos;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(i_start) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!o_found && i_mask[w_pos]) begin
        o_found = 1'b1;
        o_idx   = PTR_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates NUM_REQ write-back sources onto the two register-file write ports
// (shared enable), with round-robin fairness, same-register conflict avoidance
// and silent discard of writes to $zero.
module regfile_write_scheduler
  import regfile_sched_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      signal_reg_write,
  output logic [ADDR_W-1:0]         write_register1,
  output logic [ADDR_W-1:0]         write_register2,
  output logic [DATA_W-1:0]         write_data1,
  output logic [DATA_W-1:0]         write_data2,
  output logic [DROP_W-1:0]         drop_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(NUM_REQ + 1);

  // The slot record carries the package widths, so the ports must agree with them.
  if (DATA_W != DEF_DATA_W || ADDR_W != DEF_ADDR_W) begin : g_width_check
    $error("regfile_write_scheduler: DATA_W/ADDR_W must match regfile_sched_pkg");
  end

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [CNT_W-1:0]  b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + (DROP_W+1)'(b);
    return s[DROP_W] ? '1 : s[DROP_W-1:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
  endfunction

  logic [ADDR_W-1:0] w_addr [NUM_REQ];
  logic [DATA_W-1:0] w_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign w_data[g] = req_data[g*DATA_W +: DATA_W];
  end

  logic [PTR_W-1:0]   r_rr_ptr;
  logic               r_wen;
  logic [ADDR_W-1:0]  r_wa1, r_wa2;
  logic [DATA_W-1:0]  r_wd1, r_wd2;
  logic [DROP_W-1:0]  r_drop;

  logic [NUM_REQ-1:0] w_elig, w_zero_hit, w_mask2;
  logic [CNT_W-1:0]   w_drop_n;
  logic               w_found1, w_found2;
  logic [PTR_W-1:0]   w_idx1, w_idx2;
  wb_slot_t           w_s1, w_s2;

  always_comb begin
    w_elig     = '0;
    w_zero_hit = '0;
    w_drop_n   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_zero_hit[i] = !hold && req_valid[i] && (w_addr[i] == REG_ZERO);
      w_elig[i]     = !hold && req_valid[i] && (w_addr[i] != REG_ZERO);
      w_drop_n      = w_drop_n + CNT_W'(w_zero_hit[i]);
    end
  end

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick1 (
    .i_mask  (w_elig),
    .i_start (r_rr_ptr),
    .o_found (w_found1),
    .o_idx   (w_idx1)
  );

  always_comb begin
    w_s1.valid = w_found1;
    w_s1.addr  = w_addr[w_idx1];
    w_s1.data  = w_data[w_idx1];
  end

  // Excluding every entry that targets slot1's register keeps the two ports
  // from ever carrying different values for the same index.
  always_comb begin
    w_mask2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask2[i] = w_elig[i] && (PTR_W'(i) != w_idx1) && (w_addr[i] != w_s1.addr);
    end
  end

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick2 (
    .i_mask  (w_mask2),
    .i_start (r_rr_ptr),
    .o_found (w_found2),
    .o_idx   (w_idx2)
  );

  always_comb begin
    w_s2.valid = w_found2;
    w_s2.addr  = w_addr[w_idx2];
    w_s2.data  = w_data[w_idx2];
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_zero_hit[i]
                  || (w_s1.valid && (w_idx1 == PTR_W'(i)))
                  || (w_s2.valid && (w_idx2 == PTR_W'(i)));
    end
  end

  // With a single grant port 2 mirrors port 1, so the shared enable rewrites the same value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
      r_wen    <= 1'b0;
      r_wa1    <= '0;
      r_wa2    <= '0;
      r_wd1    <= '0;
      r_wd2    <= '0;
      r_drop   <= '0;
    end else begin
      r_wen <= w_s1.valid;
      if (w_s1.valid) begin
        r_wa1    <= w_s1.addr;
        r_wd1    <= w_s1.data;
        r_wa2    <= w_s2.valid ? w_s2.addr : w_s1.addr;
        r_wd2    <= w_s2.valid ? w_s2.data : w_s1.data;
        r_rr_ptr <= ptr_next(w_s2.valid ? w_idx2 : w_idx1);
      end
      if (w_drop_n != '0) r_drop <= sat_add(r_drop, w_drop_n);
    end
  end

  assign signal_reg_write = r_wen;
  assign write_register1  = r_wa1;
  assign write_register2  = r_wa2;
  assign write_data1      = r_wd1;
  assign write_data2      = r_wd2;
  assign drop_count       = r_drop;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: vector table, fairness/hold
// sequence and mid-cycle reset, with a scoreboard of expected port writes.
module tb_regfile_write_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        hold;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        signal_reg_write;
  logic [4:0]  write_register1, write_register2;
  logic [31:0] write_data1, write_data2;
  logic [7:0]  drop_count;

  regfile_write_scheduler dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .hold             (hold),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .signal_reg_write (signal_reg_write),
    .write_register1  (write_register1),
    .write_register2  (write_register2),
    .write_data1      (write_data1),
    .write_data2      (write_data2),
    .drop_count       (drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wen;
    logic [4:0]  wa1, wa2;
    logic [31:0] wd1, wd2;
    logic [7:0]  drop;
  } exp_t;

  typedef struct {
    logic        h;
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  rdy;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic h, input logic [2:0] v,
                              input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] a2, input logic [31:0] d2,
                              input logic [2:0] rdy, input logic wen,
                              input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic [4:0] wa2, input logic [31:0] wd2,
                              input logic [7:0] drop);
    vec_t t;
    t.h = h; t.v = v;
    t.a0 = a0; t.a1 = a1; t.a2 = a2;
    t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.rdy = rdy;
    t.e.wen = wen; t.e.wa1 = wa1; t.e.wd1 = wd1;
    t.e.wa2 = wa2; t.e.wd2 = wd2; t.e.drop = drop;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_sb: no expected entry queued", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, "_wen"},  32'(signal_reg_write), 32'(e.wen));
      chk({nm, "_wa1"},  32'(write_register1),  32'(e.wa1));
      chk({nm, "_wa2"},  32'(write_register2),  32'(e.wa2));
      chk({nm, "_wd1"},  write_data1,           e.wd1);
      chk({nm, "_wd2"},  write_data2,           e.wd2);
      chk({nm, "_drop"}, 32'(drop_count),       32'(e.drop));
    end
  endtask

  task automatic drive(input logic h, input logic [2:0] v,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    hold      = h;
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
  endtask

  // Called at a falling edge: drive, check ready, then check the registered result.
  task automatic apply(input vec_t t, input string nm, output logic [2:0] rdy_seen);
    drive(t.h, t.v, t.a0, t.a1, t.a2, t.d0, t.d1, t.d2);
    #1;
    rdy_seen = req_ready;
    chk({nm, "_ready"}, 32'(req_ready), 32'(t.rdy));
    sb.push_back(t.e);
    @(posedge clock);
    #1;
    pop_check(nm);
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1 && signal_reg_write === 1'b1) begin
      chk("inv_wr1_nonzero", 32'(write_register1 != 5'd0), 32'd1);
      chk("inv_wr2_nonzero", 32'(write_register2 != 5'd0), 32'd1);
      chk("inv_same_reg_same_data",
          32'((write_register1 != write_register2) || (write_data1 == write_data2)), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        tbl[12];
  vec_t        t;
  logic [2:0]  rdy;
  int          m_ptr;
  int          gcnt[3];
  exp_t        last;

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clock);
    chk("rst_wen",  32'(signal_reg_write), 32'd0);
    chk("rst_wa1",  32'(write_register1),  32'd0);
    chk("rst_wa2",  32'(write_register2),  32'd0);
    chk("rst_wd1",  write_data1,           32'd0);
    chk("rst_wd2",  write_data2,           32'd0);
    chk("rst_drop", 32'(drop_count),       32'd0);
    reset_n = 1'b1;

    tbl[0]  = mk(0, 3'b011, 5'd3, 32'hAAAA, 5'd7, 32'hBBBB, 5'd0, 32'h0,
                 3'b011, 1, 5'd3, 32'hAAAA, 5'd7, 32'hBBBB, 8'd0);
    tbl[1]  = mk(0, 3'b100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 32'h1234,
                 3'b100, 1, 5'd9, 32'h1234, 5'd9, 32'h1234, 8'd0);
    tbl[2]  = mk(0, 3'b011, 5'd5, 32'h11, 5'd5, 32'h22, 5'd0, 32'h0,
                 3'b001, 1, 5'd5, 32'h11, 5'd5, 32'h11, 8'd0);
    tbl[3]  = mk(0, 3'b010, 5'd5, 32'h11, 5'd5, 32'h22, 5'd0, 32'h0,
                 3'b010, 1, 5'd5, 32'h22, 5'd5, 32'h22, 8'd0);
    tbl[4]  = mk(0, 3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0,
                 3'b000, 0, 5'd5, 32'h22, 5'd5, 32'h22, 8'd0);
    tbl[5]  = mk(0, 3'b111, 5'd0, 32'hDEAD, 5'd4, 32'h44, 5'd6, 32'h66,
                 3'b111, 1, 5'd6, 32'h66, 5'd4, 32'h44, 8'd1);
    tbl[6]  = mk(1, 3'b111, 5'd0, 32'hDEAD, 5'd4, 32'h44, 5'd6, 32'h66,
                 3'b000, 0, 5'd6, 32'h66, 5'd4, 32'h44, 8'd1);
    tbl[7]  = mk(0, 3'b001, 5'd0, 32'hDEAD, 5'd0, 32'h0, 5'd0, 32'h0,
                 3'b001, 0, 5'd6, 32'h66, 5'd4, 32'h44, 8'd2);
    tbl[8]  = mk(0, 3'b111, 5'd1, 32'h101, 5'd2, 32'h202, 5'd3, 32'h303,
                 3'b101, 1, 5'd3, 32'h303, 5'd1, 32'h101, 8'd2);
    tbl[9]  = mk(0, 3'b010, 5'd0, 32'h0, 5'd2, 32'h202, 5'd0, 32'h0,
                 3'b010, 1, 5'd2, 32'h202, 5'd2, 32'h202, 8'd2);
    tbl[10] = mk(0, 3'b111, 5'd8, 32'h1, 5'd8, 32'h2, 5'd8, 32'h3,
                 3'b100, 1, 5'd8, 32'h3, 5'd8, 32'h3, 8'd2);
    tbl[11] = mk(1, 3'b001, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0,
                 3'b000, 0, 5'd8, 32'h3, 5'd8, 32'h3, 8'd2);

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i), rdy);
    end

    // Fairness with a two-cycle hold in the middle; round-robin pointer is 0 here.
    m_ptr = 0;
    gcnt[0] = 0; gcnt[1] = 0; gcnt[2] = 0;
    last = tbl[11].e;
    for (int c = 0; c < 8; c++) begin
      int s1, s2;
      t.h  = (c == 3 || c == 4);
      t.v  = 3'b111;
      t.a0 = 5'd10; t.a1 = 5'd11; t.a2 = 5'd12;
      t.d0 = 32'hF000_0000 | (c << 4) | 0;
      t.d1 = 32'hF000_0000 | (c << 4) | 1;
      t.d2 = 32'hF000_0000 | (c << 4) | 2;
      s1 = m_ptr;
      s2 = (m_ptr + 1) % 3;
      if (t.h) begin
        t.rdy = 3'b000;
        t.e   = last;
        t.e.wen = 1'b0;
      end else begin
        t.rdy      = 3'(1 << s1) | 3'(1 << s2);
        t.e.wen    = 1'b1;
        t.e.wa1    = 5'(10 + s1);
        t.e.wa2    = 5'(10 + s2);
        t.e.wd1    = 32'hF000_0000 | (c << 4) | s1;
        t.e.wd2    = 32'hF000_0000 | (c << 4) | s2;
        t.e.drop   = 8'd2;
        m_ptr      = (m_ptr + 2) % 3;
      end
      last = t.e;
      apply(t, $sformatf("fair%0d", c), rdy);
      for (int r = 0; r < 3; r++) if (rdy[r]) gcnt[r]++;
    end
    chk("fair_grants_req0", 32'(gcnt[0]), 32'd4);
    chk("fair_grants_req1", 32'(gcnt[1]), 32'd4);
    chk("fair_grants_req2", 32'(gcnt[2]), 32'd4);

    // Move the pointer off 0 so the post-reset restart is observable.
    t.h = 0; t.v = 3'b111;
    t.a0 = 5'd20; t.a1 = 5'd21; t.a2 = 5'd22;
    t.d0 = 32'h200; t.d1 = 32'h201; t.d2 = 32'h202;
    t.rdy = 3'b011;
    t.e.wen = 1; t.e.wa1 = 5'd20; t.e.wd1 = 32'h200;
    t.e.wa2 = 5'd21; t.e.wd2 = 32'h201; t.e.drop = 8'd2;
    apply(t, "pre_rst", rdy);

    drive(1'b0, 3'b111, 5'd23, 5'd24, 5'd25, 32'h300, 32'h301, 32'h302);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_wen",  32'(signal_reg_write), 32'd0);
    chk("async_rst_wa1",  32'(write_register1),  32'd0);
    chk("async_rst_wa2",  32'(write_register2),  32'd0);
    chk("async_rst_wd1",  write_data1,           32'd0);
    chk("async_rst_wd2",  write_data2,           32'd0);
    chk("async_rst_drop", 32'(drop_count),       32'd0);
    sb.delete();
    @(posedge clock);
    #1;
    chk("rst_held_wen",  32'(signal_reg_write), 32'd0);
    chk("rst_held_wa1",  32'(write_register1),  32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    t.h = 0; t.v = 3'b111;
    t.a0 = 5'd10; t.a1 = 5'd11; t.a2 = 5'd12;
    t.d0 = 32'h400; t.d1 = 32'h401; t.d2 = 32'h402;
    t.rdy = 3'b011;
    t.e.wen = 1; t.e.wa1 = 5'd10; t.e.wd1 = 32'h400;
    t.e.wa2 = 5'd11; t.e.wd2 = 32'h401; t.e.drop = 8'd0;
    apply(t, "post_rst", rdy);

    drive(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
